// File: rtl/wb_dshot_encoder.sv
// Wishbone-mapped four-channel DSHOT frame generator.
// All channels shift out aligned 16-bit frames, one-shot or on a refresh timer.
module wb_dshot_encoder #(
  parameter int CLK_FREQ_HZ    = 54_000_000,
  parameter int DSHOT_KBPS     = 150,
  parameter int GAP_CYCLES     = 1080,
  parameter int REFRESH_CYCLES = 54_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic [3:0]  dshot_out,
  output logic        busy
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / (DSHOT_KBPS * 1000);
  localparam int T1H = (BIT_CYCLES * 3) / 4;
  localparam int T0H = (BIT_CYCLES * 3) / 8;

  localparam int BW = $clog2(BIT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] T1H_C    = BW'(T1H);
  localparam logic [BW-1:0] T0H_C    = BW'(T0H);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_BIT  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state;
  logic [11:0]   shadow [4];
  logic [15:0]   shift_q [4];
  logic [BW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] ref_cnt;
  logic          refresh_en;
  logic          refresh_due;
  logic          pending;

  logic [9:0]  reg_idx;
  logic        sel;
  logic        xfer;
  logic        wr;
  logic        is_motor;
  logic        is_ctrl;
  logic        expire;
  logic [31:0] rdata;
  logic        unused_ok;

  assign reg_idx    = wb_adr_i[11:2];
  assign sel        = wb_cyc_i & wb_stb_i;
  assign xfer       = sel & ~wb_ack_o;
  assign wr         = xfer & wb_we_i;
  assign is_motor   = (reg_idx[9:2] == 8'h30);
  assign is_ctrl    = (reg_idx == 10'h0C4);
  assign busy       = (state != S_IDLE);
  assign wb_stall_o = 1'b0;
  assign expire     = refresh_en & (ref_cnt == REF_LAST);
  assign unused_ok  = &{1'b0, wb_sel_i, wb_adr_i[31:12],
                        wb_adr_i[1:0], wb_dat_i[31:12]};

  function automatic logic [15:0] mk_frame(input logic [11:0] s);
    logic [11:0] v;
    v = {s[10:0], s[11]};
    return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
  endfunction

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_motor: rdata = {20'b0, shadow[reg_idx[1:0]]};
      is_ctrl:  rdata = {29'b0, busy, pending, refresh_en};
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      refresh_en <= 1'b0;
      pending    <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      wb_ack_o <= xfer;
      if (xfer) wb_dat_o <= rdata;
      if (wr && is_motor) shadow[reg_idx[1:0]] <= wb_dat_i[11:0];
      if (wr && is_ctrl) refresh_en <= wb_dat_i[0];
      // a write landing during LOAD must survive the clear
      if (wr && is_motor) pending <= 1'b1;
      else if (state == S_LOAD) pending <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ref_cnt     <= '0;
      refresh_due <= 1'b0;
    end else begin
      if (!refresh_en || ref_cnt == REF_LAST) ref_cnt <= '0;
      else ref_cnt <= ref_cnt + 1'b1;
      if (expire) refresh_due <= 1'b1;
      else if (state == S_LOAD || !refresh_en) refresh_due <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < 4; i++) shift_q[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pending || (refresh_en && refresh_due)) state <= S_LOAD;
        end
        S_LOAD: begin
          for (int i = 0; i < 4; i++) shift_q[i] <= mk_frame(shadow[i]);
          bit_cnt <= '0;
          bit_idx <= 4'd15;
          state   <= S_BIT;
        end
        S_BIT: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            for (int i = 0; i < 4; i++) shift_q[i] <= {shift_q[i][14:0], 1'b0};
            if (bit_idx == 4'd0) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dshot_out = '0;
    for (int i = 0; i < 4; i++)
      dshot_out[i] = (state == S_BIT) &&
                     (bit_cnt < (shift_q[i][15] ? T1H_C : T0H_C));
  end

endmodule

// File: tb/tb_wb_dshot_encoder.sv
// Directed bench for wb_dshot_encoder.
// Frames are decoded from measured high times and compared with hand values.
module tb_wb_dshot_encoder;

  localparam int REF   = 7000;
  localparam int BITC  = 360;
  localparam int T1H   = 270;
  localparam int T0H   = 135;
  localparam int GAP   = 1080;
  localparam int FRAME = 16 * BITC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dat_i = '0;
  logic [31:0] adr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'hF;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        stall_o;
  logic [3:0]  dshot_out;
  logic        busy;

  wb_dshot_encoder #(
    .CLK_FREQ_HZ(54_000_000),
    .DSHOT_KBPS(150),
    .GAP_CYCLES(GAP),
    .REFRESH_CYCLES(REF)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .wb_dat_i(dat_i),
    .wb_adr_i(adr_i),
    .wb_we_i(we_i),
    .wb_sel_i(sel_i),
    .wb_stb_i(stb_i),
    .wb_cyc_i(cyc_i),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack_o),
    .wb_stall_o(stall_o),
    .dshot_out(dshot_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cycles = 0;
  always @(posedge clk) cycles <= cycles + 1;

  int total = 0;
  int bad = 0;

  logic [15:0] cap_fr [4];
  logic [15:0] exp_fr [4];
  int cap_rise, cap_end, cap_badw, cap_gaphi;
  bit cap_ok;

  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rd,
                         output int ackc);
    int w;
    w = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
    @(negedge clk);
    while (!ack_o && w < 20) begin @(negedge clk); w++; end
    ackc = cycles;
    rd = dat_o;
    total++;
    if (ack_o !== 1'b1) begin
      bad++;
      $display("FAIL wb_ack adr=%h got=%b exp=1", adr, ack_o);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic capture(input int limit);
    int hc [4];
    int w;
    cap_ok = 0; cap_badw = 0; cap_gaphi = 0; cap_rise = 0; cap_end = 0;
    for (int c = 0; c < 4; c++) cap_fr[c] = '0;
    w = 0;
    while (dshot_out == 4'b0 && w < limit) begin @(negedge clk); w++; end
    if (dshot_out == 4'b0) return;
    cap_ok = 1;
    cap_rise = cycles;
    for (int b = 0; b < 16; b++) begin
      for (int c = 0; c < 4; c++) hc[c] = 0;
      for (int k = 0; k < BITC; k++) begin
        for (int c = 0; c < 4; c++) if (dshot_out[c]) hc[c]++;
        @(negedge clk);
      end
      for (int c = 0; c < 4; c++) begin
        if (hc[c] != T1H && hc[c] != T0H) cap_badw++;
        cap_fr[c] = {cap_fr[c][14:0], hc[c] == T1H};
      end
    end
    w = 0;
    while (busy && w < GAP + 100) begin
      if (dshot_out != 4'b0) cap_gaphi++;
      @(negedge clk); w++;
    end
    cap_end = cycles;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dshot_out !== 4'b0) begin bad++; $display("FAIL rst_dshot got=%h exp=0", dshot_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack_o); end
    total++;
    if (dat_o !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic [31:0] rd;
    int ackc;
    wb_xfer(1'b1, 32'h300, 32'h416, rd, ackc);
    capture(100);
    total++;
    if (!cap_ok || cap_rise != ackc + 2) begin
      bad++; $display("FAIL latency got=%0d exp=%0d", cap_rise - ackc, 2);
    end
    exp_fr[0] = 16'h82C6; exp_fr[1] = 16'h0; exp_fr[2] = 16'h0; exp_fr[3] = 16'h0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (cap_fr[c] !== exp_fr[c]) begin
        bad++; $display("FAIL single_ch%0d got=%h exp=%h", c, cap_fr[c], exp_fr[c]);
      end
    end
    total++;
    if (cap_badw != 0) begin bad++; $display("FAIL single_width got=%0d exp=0", cap_badw); end
    total++;
    if (cap_end != cap_rise + FRAME + GAP) begin
      bad++; $display("FAIL busy_fall got=%0d exp=%0d", cap_end - cap_rise, FRAME + GAP);
    end
    total++;
    if (cap_gaphi != 0) begin bad++; $display("FAIL gap_low got=%0d exp=0", cap_gaphi); end
    capture(3000);
    total++;
    if (cap_ok) begin bad++; $display("FAIL one_shot got=1 exp=0"); end
  endtask

  task automatic test_motor2;
    logic [31:0] rd;
    int ackc;
    wb_xfer(1'b1, 32'h308, 32'h830, rd, ackc);
    capture(100);
    exp_fr[0] = 16'h82C6; exp_fr[1] = 16'h0; exp_fr[2] = 16'h0617; exp_fr[3] = 16'h0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (cap_fr[c] !== exp_fr[c]) begin
        bad++; $display("FAIL m2_ch%0d got=%h exp=%h", c, cap_fr[c], exp_fr[c]);
      end
    end
    wb_xfer(1'b0, 32'h308, 32'h0, rd, ackc);
    total++;
    if (rd !== 32'h830) begin bad++; $display("FAIL m2_read got=%h exp=830", rd); end
  endtask

  task automatic test_refresh;
    logic [31:0] rd;
    int ackc;
    int prev;
    wb_xfer(1'b1, 32'h310, 32'h1, rd, ackc);
    exp_fr[0] = 16'h82C6; exp_fr[1] = 16'h0; exp_fr[2] = 16'h0617; exp_fr[3] = 16'h0;
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      capture(2 * REF);
      total++;
      if (!cap_ok) begin bad++; $display("FAIL refresh_start%0d got=0 exp=1", f); end
      for (int c = 0; c < 4; c++) begin
        total++;
        if (cap_fr[c] !== exp_fr[c]) begin
          bad++; $display("FAIL refresh%0d_ch%0d got=%h exp=%h", f, c, cap_fr[c], exp_fr[c]);
        end
      end
      if (f > 0) begin
        total++;
        if (cap_rise - prev != REF) begin
          bad++; $display("FAIL refresh_period got=%0d exp=%0d", cap_rise - prev, REF);
        end
      end
      prev = cap_rise;
    end
    wb_xfer(1'b1, 32'h310, 32'h0, rd, ackc);
    wb_xfer(1'b0, 32'h310, 32'h0, rd, ackc);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL status_idle got=%h exp=0", rd); end
  endtask

  task automatic test_midframe_write;
    logic [31:0] rd;
    int ackc;
    int rise1, end1;
    wb_xfer(1'b1, 32'h304, 32'h100, rd, ackc);
    fork
      capture(100);
      begin
        repeat (1500) @(negedge clk);
        wb_xfer(1'b1, 32'h304, 32'h200, rd, ackc);
      end
    join
    rise1 = cap_rise; end1 = cap_end;
    total++;
    if (cap_fr[1] !== 16'h2002) begin bad++; $display("FAIL mid_old got=%h exp=2002", cap_fr[1]); end
    capture(100);
    total++;
    if (cap_fr[1] !== 16'h4004) begin bad++; $display("FAIL mid_new got=%h exp=4004", cap_fr[1]); end
    total++;
    if (cap_fr[0] !== 16'h82C6) begin bad++; $display("FAIL mid_ch0 got=%h exp=82c6", cap_fr[0]); end
    total++;
    if (!cap_ok || cap_rise - rise1 != FRAME + GAP + 2) begin
      bad++; $display("FAIL mid_spacing got=%0d exp=%0d", cap_rise - rise1, FRAME + GAP + 2);
    end
    total++;
    if (cap_rise != end1 + 2) begin
      bad++; $display("FAIL mid_restart got=%0d exp=2", cap_rise - end1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    int ackc;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h314;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ack_o !== ((i % 2) == 0)) begin
        bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, ack_o, (i % 2) == 0);
      end
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall_o); end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    wb_xfer(1'b1, 32'h314, 32'hFFFF_FFFF, rd, ackc);
    wb_xfer(1'b0, 32'h314, 32'h0, rd, ackc);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", rd); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rd;
    int ackc;
    int w;
    int hi;
    wb_xfer(1'b1, 32'h30C, 32'h7FF, rd, ackc);
    w = 0;
    while (dshot_out == 4'b0 && w < 100) begin @(negedge clk); w++; end
    repeat (8 * BITC + 50) @(negedge clk);
    total++;
    if (dshot_out[3] !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL bit7_state got=%b/%b exp=1/1", dshot_out[3], busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dshot_out !== 4'b0) begin bad++; $display("FAIL rst_mid_dshot got=%h exp=0", dshot_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_xfer(1'b0, 32'h310, 32'h0, rd, ackc);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", rd); end
    wb_xfer(1'b0, 32'h30C, 32'h0, rd, ackc);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_shadow got=%h exp=0", rd); end
    hi = 0;
    repeat (REF) begin
      @(negedge clk);
      if (dshot_out != 4'b0 || busy) hi++;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL rst_silent got=%0d exp=0", hi); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_motor2();
    test_refresh();
    test_midframe_write();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
